// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out stream bundle for byte_word_packer.
// The packer takes the slave view; the byte source and word consumer take the master view.
interface byte_word_packer_if #(
  parameter int WORD_BYTES = 4
);
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int CNT_W  = $clog2(WORD_BYTES + 1);

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_bytes;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_bytes, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_bytes, out_last
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into WORD_BYTES-wide words through a two-bank
// ping-pong buffer: one bank fills while the other drains, sustaining 1 byte/clk.
module byte_word_packer #(
  parameter int WORD_BYTES = 4,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  byte_word_packer_if.slave  bus
);
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int BPOS_W = $clog2(WORD_BYTES);
  localparam int CNT_W  = $clog2(WORD_BYTES + 1);
  localparam logic [BPOS_W-1:0] BPOS_MAX = BPOS_W'(WORD_BYTES - 1);

  logic                   wsel_r;
  logic                   rsel_r;
  logic [BPOS_W-1:0]      bpos_r;
  logic [1:0]             full_r;
  logic [1:0][CNT_W-1:0]  cnt_r;
  logic [1:0]             lastf_r;
  logic [1:0][DATA_W-1:0] bank_r;

  logic                   accept_s;
  logic                   drain_s;
  logic                   close_s;
  logic [BPOS_W-1:0]      lane_s;
  logic [CNT_W-1:0]       cnt_next_s;

  // Byte lane for a word position; MSB-first mode mirrors the lane order.
  function automatic logic [BPOS_W-1:0] lane_of(input logic [BPOS_W-1:0] pos);
    logic [BPOS_W-1:0] lane;
    if (LSB_FIRST) begin
      lane = pos;
    end else begin
      lane = BPOS_MAX - pos;
    end
    return lane;
  endfunction

  // Handshake qualifiers and the write lane of the byte being offered.
  always_comb begin
    accept_s   = bus.in_valid && !full_r[wsel_r];
    drain_s    = bus.out_ready && full_r[rsel_r];
    close_s    = accept_s && ((bpos_r == BPOS_MAX) || bus.in_last);
    lane_s     = lane_of(bpos_r);
    cnt_next_s = CNT_W'(bpos_r) + CNT_W'(1);
  end

  // Bank state: drain clears the read bank, accept writes the fill bank.
  // The two never target the same bank in one cycle, since a bank is
  // either full (drainable) or not full (fillable).
  always_ff @(posedge clk) begin
    if (rst) begin
      wsel_r  <= 1'b0;
      rsel_r  <= 1'b0;
      bpos_r  <= '0;
      full_r  <= 2'b00;
      cnt_r   <= '0;
      lastf_r <= 2'b00;
      bank_r  <= '0;
    end else begin
      if (drain_s) begin
        full_r[rsel_r]  <= 1'b0;
        bank_r[rsel_r]  <= '0;
        cnt_r[rsel_r]   <= '0;
        lastf_r[rsel_r] <= 1'b0;
        rsel_r          <= ~rsel_r;
      end
      if (accept_s) begin
        bank_r[wsel_r][{lane_s, 3'b000} +: 8] <= bus.in_data;
        if (close_s) begin
          full_r[wsel_r]  <= 1'b1;
          cnt_r[wsel_r]   <= cnt_next_s;
          lastf_r[wsel_r] <= bus.in_last;
          wsel_r          <= ~wsel_r;
          bpos_r          <= '0;
        end else begin
          bpos_r <= bpos_r + BPOS_W'(1);
        end
      end
    end
  end

  // Outputs present the read bank directly so a word is visible the cycle
  // after its closing byte.
  always_comb begin
    bus.in_ready  = !full_r[wsel_r];
    bus.out_valid = full_r[rsel_r];
    bus.out_data  = bank_r[rsel_r];
    bus.out_bytes = cnt_r[rsel_r];
    bus.out_last  = lastf_r[rsel_r];
  end
endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: an LSB-first instance carries most
// sequences, an MSB-first instance checks lane ordering and 1-byte flush.
module tb_byte_word_packer;
  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  byte_word_packer_if #(.WORD_BYTES(4)) bus   ();
  byte_word_packer_if #(.WORD_BYTES(4)) bus_m ();

  byte_word_packer #(.WORD_BYTES(4), .LSB_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  byte_word_packer #(.WORD_BYTES(4), .LSB_FIRST(1'b0)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  logic [31:0] q_data [$];
  int          q_bytes[$];
  bit          q_last [$];
  int          q_cyc  [$];
  int          acc_cnt;
  int          last_acc_cyc;
  int          stall_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Word capture and input handshake bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      q_data.push_back(bus.out_data);
      q_bytes.push_back(int'(bus.out_bytes));
      q_last.push_back(bus.out_last);
      q_cyc.push_back(cyc);
    end
    if (bus.in_valid && bus.in_ready) begin
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    if (bus.in_valid && !bus.in_ready) stall_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_bytes.delete();
    q_last.delete();
    q_cyc.delete();
    acc_cnt   = 0;
    stall_cnt = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d, input logic l);
    bit got;
    got          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("send_accepted", 64'(got), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  logic [7:0] mv [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    idle();
    bus.out_ready   = 1'b0;
    bus_m.in_valid  = 1'b0;
    bus_m.in_data   = 8'h00;
    bus_m.in_last   = 1'b0;
    bus_m.out_ready = 1'b0;
    clear_q();
    wait_cycles(2);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_data",  64'(bus.out_data),  64'h0);
    check_eq("rst_out_bytes", 64'(bus.out_bytes), 64'd0);
    check_eq("rst_out_last",  64'(bus.out_last),  64'd0);
    @(posedge clk);
    #1;

    // 1: eight bytes back-to-back, consumer always ready
    bus.out_ready = 1'b1;
    clear_q();
    for (int k = 1; k <= 8; k++) send(8'(k * 8'h11), 1'b0);
    idle();
    wait_cycles(4);
    check_eq("t1_words",  64'(q_data.size()), 64'd2);
    check_eq("t1_w0",     64'(q_data[0]), 64'h44332211);
    check_eq("t1_w1",     64'(q_data[1]), 64'h88776655);
    check_eq("t1_bytes0", 64'(q_bytes[0]), 64'd4);
    check_eq("t1_bytes1", 64'(q_bytes[1]), 64'd4);
    check_eq("t1_last0",  64'(q_last[0]), 64'd0);
    check_eq("t1_spacing", 64'(q_cyc[1] - q_cyc[0]), 64'd4);

    // 2: flush after 3 bytes, then a 1-byte word
    clear_q();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b1);
    send(8'h5A, 1'b1);
    idle();
    wait_cycles(4);
    check_eq("t2_words",  64'(q_data.size()), 64'd2);
    check_eq("t2_w0",     64'(q_data[0]), 64'h00A3A2A1);
    check_eq("t2_bytes0", 64'(q_bytes[0]), 64'd3);
    check_eq("t2_last0",  64'(q_last[0]), 64'd1);
    check_eq("t2_w1",     64'(q_data[1]), 64'h0000005A);
    check_eq("t2_bytes1", 64'(q_bytes[1]), 64'd1);
    check_eq("t2_last1",  64'(q_last[1]), 64'd1);

    // 3: consumer stalled while 12 bytes are offered
    bus.out_ready = 1'b0;
    clear_q();
    fork
      begin
        for (int k = 0; k < 12; k++) send(8'(8'h30 + k), 1'b0);
        idle();
      end
      begin
        wait_cycles(20);
        @(negedge clk);
        check_eq("t3_acc_stalled", 64'(acc_cnt),       64'd8);
        check_eq("t3_in_ready",    64'(bus.in_ready),  64'd0);
        check_eq("t3_out_valid",   64'(bus.out_valid), 64'd1);
        check_eq("t3_no_drain",    64'(q_data.size()), 64'd0);
        bus.out_ready = 1'b1;
      end
    join
    wait_cycles(6);
    check_eq("t3_acc_total", 64'(acc_cnt), 64'd12);
    check_eq("t3_words", 64'(q_data.size()), 64'd3);
    check_eq("t3_w0", 64'(q_data[0]), 64'h33323130);
    check_eq("t3_w1", 64'(q_data[1]), 64'h37363534);
    check_eq("t3_w2", 64'(q_data[2]), 64'h3B3A3938);

    // 4: sustained rate, 64 bytes at one per clock
    clear_q();
    for (int k = 0; k < 64; k++) send(8'(k), 1'b0);
    idle();
    wait_cycles(4);
    check_eq("t4_stalls", 64'(stall_cnt), 64'd0);
    check_eq("t4_words",  64'(q_data.size()), 64'd16);
    for (int w = 0; w < 16; w++) begin
      check_eq($sformatf("t4_w%0d", w), 64'(q_data[w]),
               64'({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}));
    end
    check_eq("t4_latency", 64'(q_cyc[15] - last_acc_cyc), 64'd1);

    // 5: reset with one word pending and a partial word in the other bank
    bus.out_ready = 1'b0;
    clear_q();
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h64, 1'b0);
    send(8'hEE, 1'b0);
    send(8'hEF, 1'b0);
    idle();
    @(negedge clk);
    check_eq("t5_pending", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("t5_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("t5_out_data",  64'(bus.out_data),  64'h0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    clear_q();
    for (int k = 1; k <= 4; k++) send(8'(k), 1'b0);
    idle();
    wait_cycles(4);
    check_eq("t5_words", 64'(q_data.size()), 64'd1);
    check_eq("t5_w0",    64'(q_data[0]), 64'h04030201);

    // 6: MSB-first instance
    mv[0] = 8'h11;
    mv[1] = 8'h22;
    mv[2] = 8'h33;
    mv[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      bus_m.in_valid = 1'b1;
      bus_m.in_data  = mv[k];
      @(negedge clk);
      check_eq($sformatf("t6_ready%0d", k), 64'(bus_m.in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    bus_m.in_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_valid", 64'(bus_m.out_valid), 64'd1);
    check_eq("t6_data",  64'(bus_m.out_data),  64'h11223344);
    check_eq("t6_bytes", 64'(bus_m.out_bytes), 64'd4);
    check_eq("t6_last",  64'(bus_m.out_last),  64'd0);
    bus_m.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_m.out_ready = 1'b0;
    bus_m.in_valid  = 1'b1;
    bus_m.in_data   = 8'h55;
    bus_m.in_last   = 1'b1;
    @(posedge clk);
    #1;
    bus_m.in_valid = 1'b0;
    bus_m.in_last  = 1'b0;
    @(negedge clk);
    check_eq("t6_flush_data",  64'(bus_m.out_data),  64'h55000000);
    check_eq("t6_flush_bytes", 64'(bus_m.out_bytes), 64'd1);
    check_eq("t6_flush_last",  64'(bus_m.out_last),  64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
